// File: rtl/ov7670_config_seq.sv
// Reads the OV7670 configuration ROM from address 0 and issues each entry as an SCCB register write.
// Optional OV7670_CFG_AUTOSTART_EN: start the sequence automatically one cycle after reset.
module ov7670_config_seq #(
    parameter int unsigned DELAY_CYCLES = 240000,
    parameter int unsigned ROM_AW       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_dout,
    input  logic              i_sccb_ready,
    output logic              o_sccb_start,
    output logic [7:0]        o_sccb_reg,
    output logic [7:0]        o_sccb_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [23:0]       DelayLoad = 24'(DELAY_CYCLES - 1);
    localparam logic [ROM_AW-1:0] AddrLast  = '1;
    localparam logic [15:0]       MarkEnd   = 16'hFFFF;
    localparam logic [15:0]       MarkDelay = 16'hFFF0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StGuard,
        StWaitSccb,
        StDelay,
        StFinish
    } state_e;

    state_e            r_state,     w_state_nxt;
    logic [ROM_AW-1:0] r_rom_addr,  w_rom_addr_nxt;
    logic [7:0]        r_sccb_reg,  w_sccb_reg_nxt;
    logic [7:0]        r_sccb_data, w_sccb_data_nxt;
    logic [23:0]       r_cnt,       w_cnt_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              w_start;
    logic              w_sccb_start;

`ifdef OV7670_CFG_AUTOSTART_EN
    // High only during the first clock after reset release: acts as an internal start pulse.
    logic r_auto;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_auto <= 1'b1;
        end else begin
            r_auto <= 1'b0;
        end
    end

    assign w_start = i_start | r_auto;
`else
    assign w_start = i_start;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_rom_addr_nxt  = r_rom_addr;
        w_sccb_reg_nxt  = r_sccb_reg;
        w_sccb_data_nxt = r_sccb_data;
        w_cnt_nxt       = r_cnt;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_sccb_start    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_rom_addr_nxt = '0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_state_nxt    = StFetch;
                end
            end
            StFetch: begin
                w_state_nxt = StDecode;
            end
            StDecode: begin
                if (i_rom_dout == MarkEnd) begin
                    w_state_nxt = StFinish;
                end else if (i_rom_dout == MarkDelay) begin
                    w_cnt_nxt   = DelayLoad;
                    w_state_nxt = StDelay;
                end else begin
                    w_sccb_reg_nxt  = i_rom_dout[15:8];
                    w_sccb_data_nxt = i_rom_dout[7:0];
                    w_state_nxt     = StIssue;
                end
            end
            StIssue: begin
                if (i_sccb_ready) begin
                    w_sccb_start = 1'b1;
                    w_state_nxt  = StGuard;
                end
            end
            // Master may still show ready for a cycle after accepting; skip it.
            StGuard: begin
                w_state_nxt = StWaitSccb;
            end
            StWaitSccb: begin
                if (i_sccb_ready) begin
                    if (r_rom_addr == AddrLast) begin
                        w_state_nxt = StFinish;
                    end else begin
                        w_rom_addr_nxt = r_rom_addr + ROM_AW'(1);
                        w_state_nxt    = StFetch;
                    end
                end
            end
            StDelay: begin
                if (r_cnt == '0) begin
                    if (r_rom_addr == AddrLast) begin
                        w_state_nxt = StFinish;
                    end else begin
                        w_rom_addr_nxt = r_rom_addr + ROM_AW'(1);
                        w_state_nxt    = StFetch;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            StFinish: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_rom_addr  <= '0;
            r_sccb_reg  <= '0;
            r_sccb_data <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rom_addr  <= w_rom_addr_nxt;
            r_sccb_reg  <= w_sccb_reg_nxt;
            r_sccb_data <= w_sccb_data_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign o_rom_addr   = r_rom_addr;
    assign o_sccb_start = w_sccb_start;
    assign o_sccb_reg   = r_sccb_reg;
    assign o_sccb_data  = r_sccb_data;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Randomized bench for ov7670_config_seq: ROM and SCCB models plus a reference list of expected writes.
module tb_ov7670_config_seq;

    localparam int unsigned N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout = 16'h0000;
    logic        sccb_ready = 1'b1;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    ov7670_config_seq #(
        .DELAY_CYCLES(N),
        .ROM_AW      (8)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_rom_addr  (rom_addr),
        .i_rom_dout  (rom_dout),
        .i_sccb_ready(sccb_ready),
        .o_sccb_start(sccb_start),
        .o_sccb_reg  (sccb_reg),
        .o_sccb_data (sccb_data),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Registered ROM model
    logic [15:0] rom [256];
    always @(posedge clk) rom_dout <= rom[rom_addr];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture of accepted writes, sampled at negedge
    logic [15:0] cap_q[$];
    int          cap_t[$];
    int          cyc = 0;
    int          bad_pulse = 0;
    bit          acc = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (sccb_start) begin
            cap_q.push_back({sccb_reg, sccb_data});
            cap_t.push_back(cyc);
            if (!sccb_ready) bad_pulse++;
            acc = 1'b1;
        end
    end

    // SCCB model: after an accept, ready stays low for lat cycles
    int lat = 0;
    bit force_low = 1'b0;
    int hold = 0;

    always begin
        @(posedge clk);
        #1;
        if (force_low) begin
            sccb_ready = 1'b0;
            hold = 0;
        end else if (acc && lat > 0) begin
            hold = lat;
            sccb_ready = 1'b0;
        end else if (hold > 1) begin
            hold--;
        end else begin
            hold = 0;
            sccb_ready = 1'b1;
        end
        acc = 1'b0;
    end

    // Reference: list of writes, delay markers preceding each, final address
    logic [15:0] exp_w[$];
    int          exp_k[$];
    int          exp_addr;

    function automatic void build_expected();
        int k;
        k = 0;
        exp_w.delete();
        exp_k.delete();
        exp_addr = 255;
        for (int a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) begin
                exp_addr = a;
                return;
            end else if (rom[a] == 16'hFFF0) begin
                k++;
            end else begin
                exp_w.push_back(rom[a]);
                exp_k.push_back(k);
                k = 0;
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic reset_and_kick(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq({tag, "_rst_addr"},  {24'h0, rom_addr},  32'h0);
        check_eq({tag, "_rst_start"}, {31'h0, sccb_start}, 32'h0);
        check_eq({tag, "_rst_reg"},   {24'h0, sccb_reg},  32'h0);
        check_eq({tag, "_rst_data"},  {24'h0, sccb_data}, 32'h0);
        check_eq({tag, "_rst_busy"},  {31'h0, busy},      32'h0);
        check_eq({tag, "_rst_done"},  {31'h0, done},      32'h0);
        cap_q.delete();
        cap_t.delete();
        bad_pulse = 0;
        rst_n = 1'b1;
`ifdef OV7670_CFG_AUTOSTART_EN
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        check_eq({tag, "_autostart_busy"}, {31'h0, busy}, 32'h1);
`else
        pulse_start();
`endif
    endtask

    task automatic finish_check(input string tag);
        int n;
        int m;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, {31'h0, done}, 32'h1);
        check_eq({tag, "_nwrites"}, cap_q.size(), exp_w.size());
        m = (cap_q.size() < exp_w.size()) ? cap_q.size() : exp_w.size();
        for (int i = 0; i < m; i++) begin
            check_eq($sformatf("%s_write%0d", tag, i), {16'h0, cap_q[i]}, {16'h0, exp_w[i]});
            if (lat == 0 && i > 0)
                check_eq($sformatf("%s_gap%0d", tag, i), cap_t[i] - cap_t[i-1],
                         5 + exp_k[i] * (N + 2));
        end
        check_eq({tag, "_addr"}, {24'h0, rom_addr}, exp_addr);
        check_eq({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
        check_eq({tag, "_bad_pulse"}, bad_pulse, 0);
    endtask

    task automatic run_check(input string tag, input int l, input bit do_reset);
        build_expected();
        lat = l;
        if (do_reset) begin
            reset_and_kick(tag);
        end else begin
            cap_q.delete();
            cap_t.delete();
            bad_pulse = 0;
            pulse_start();
            check_eq({tag, "_busy_rise"}, {31'h0, busy}, 32'h1);
            check_eq({tag, "_done_clr"}, {31'h0, done}, 32'h0);
        end
        finish_check(tag);
    endtask

    task automatic load_directed();
        for (int a = 0; a < 256; a++) rom[a] = 16'h5555;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1204;
        rom[3] = 16'hFFFF;
    endtask

    initial begin
        int n;
        int stray;
        int len;
        logic [15:0] v;

        load_directed();
        run_check("dir", 0, 1'b1);
        run_check("slow", 50, 1'b1);
        run_check("rerun", 0, 1'b0);

        // Ready held low while the first write is pending
        build_expected();
        lat = 0;
        force_low = 1'b1;
        reset_and_kick("hold");
        stray = 0;
        repeat (24) begin
            @(negedge clk);
            if (sccb_start) stray++;
        end
        check_eq("hold_no_start", stray, 0);
        check_eq("hold_reg", {24'h0, sccb_reg}, 32'h12);
        check_eq("hold_data", {24'h0, sccb_data}, 32'h80);
        force_low = 1'b0;
        @(negedge clk);
        check_eq("hold_first_ready_pulse", {31'h0, sccb_start}, 32'h1);
        finish_check("hold");

        // Reset while counting down a delay marker
        load_directed();
        lat = 0;
        reset_and_kick("pre");
        n = 0;
        while (cap_q.size() < 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("pre_first_write", cap_q.size(), 1);
        repeat (8) @(negedge clk);
        check_eq("pre_delay_addr", {24'h0, rom_addr}, 32'h1);
        check_eq("pre_delay_busy", {31'h0, busy}, 32'h1);
        run_check("midrst", 0, 1'b1);

        // Immediate end marker
        rom[0] = 16'hFFFF;
        run_check("empty", 0, 1'b1);

        // No end marker anywhere: runs to the last address and stops
        for (int a = 0; a < 256; a++) rom[a] = 16'h0101;
        run_check("full", 0, 1'b1);

        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 256; a++) begin
                v = 16'($urandom);
                if (v[15:4] == 12'hFFF) v[15] = 1'b0;
                rom[a] = v;
            end
            len = $urandom_range(1, 10);
            for (int a = 0; a < len; a++)
                if ($urandom_range(0, 3) == 0) rom[a] = 16'hFFF0;
            rom[len] = 16'hFFFF;
            run_check($sformatf("rnd%0d", it), (it % 2 == 0) ? 0 : $urandom_range(1, 6),
                      (it % 3) != 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
